// File: rtl/sargantana_icache_pkg.sv
// rtl/sargantana_icache_pkg.sv - shared widths and FSM state encoding for the icache way controller
//
// Purpose : widths of the way RAM (set index and line) and the two-state
//           controller encoding, shared by the controller and its users.
// Contents: ADDR_WIDHT, SET_WIDHT, way_ctrl_state_t, STATE_IDLE, STATE_FLUSH.
package sargantana_icache_pkg;

  localparam int ADDR_WIDHT = 7;
  localparam int SET_WIDHT  = 32;

  typedef logic [0:0] way_ctrl_state_t;

  localparam way_ctrl_state_t STATE_IDLE  = 1'b0;
  localparam way_ctrl_state_t STATE_FLUSH = 1'b1;

endpackage

// File: rtl/sargantana_icache_way_ctrl.sv
// rtl/sargantana_icache_way_ctrl.sv - arbitration and flush walker in front of one icache way RAM
//
// Purpose : issues at most one way RAM access per cycle with fixed priority
//           flush walk > refill write > lookup read, returns lookup data one
//           cycle after the read grant, and walks every set writing
//           FLUSH_DATA on a flush request.
// Config  : SARGANTANA_ICACHE_RESET_FLUSH_EN defined -> reset parks the FSM in
//           FLUSH so a full walk runs after reset deasserts.
// Ports   : clk_i, rst_i (async, active-high)
//           flush_req_i                       flush pulse
//           refill_req_i/addr_i/data_i/gnt_o  refill write port
//           lookup_req_i/addr_i/gnt_o         lookup read port
//           lookup_valid_o/lookup_data_o      lookup response
//           flush_busy_o                      walk in progress
//           ram_req_o/we_o/addr_o/data_o      way RAM command
//           ram_data_i                        way RAM read data (1 cycle)
module sargantana_icache_way_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter int                   NUM_SETS   = 2**ADDR_WIDHT,
  parameter logic [SET_WIDHT-1:0] FLUSH_DATA = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_req_i,
  input  logic                  refill_req_i,
  input  logic [ADDR_WIDHT-1:0] refill_addr_i,
  input  logic [SET_WIDHT-1:0]  refill_data_i,
  output logic                  refill_gnt_o,
  input  logic                  lookup_req_i,
  input  logic [ADDR_WIDHT-1:0] lookup_addr_i,
  output logic                  lookup_gnt_o,
  output logic                  lookup_valid_o,
  output logic [SET_WIDHT-1:0]  lookup_data_o,
  output logic                  flush_busy_o,
  output logic                  ram_req_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDHT-1:0] ram_addr_o,
  output logic [SET_WIDHT-1:0]  ram_data_o,
  input  logic [SET_WIDHT-1:0]  ram_data_i
);

  localparam logic [ADDR_WIDHT-1:0] LAST_SET = ADDR_WIDHT'(NUM_SETS - 1);

`ifdef SARGANTANA_ICACHE_RESET_FLUSH_EN
  localparam way_ctrl_state_t RESET_STATE = STATE_FLUSH;
`else
  localparam way_ctrl_state_t RESET_STATE = STATE_IDLE;
`endif

  way_ctrl_state_t         state_q, state_d;
  logic [ADDR_WIDHT-1:0]   cnt_q, cnt_d;
  logic                    valid_q, valid_d;

  logic                    ram_req;
  logic                    ram_we;
  logic [ADDR_WIDHT-1:0]   ram_addr;
  logic [SET_WIDHT-1:0]    ram_data;
  logic                    refill_gnt;
  logic                    lookup_gnt;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ram_req    = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_data   = '0;
    refill_gnt = 1'b0;
    lookup_gnt = 1'b0;

    if (state_q == STATE_FLUSH) begin
      ram_req  = 1'b1;
      ram_we   = 1'b1;
      ram_addr = cnt_q;
      ram_data = FLUSH_DATA;
      // A new request restarts the walk; the current set is still written.
      if (flush_req_i) begin
        cnt_d = '0;
      end else if (cnt_q == LAST_SET) begin
        cnt_d   = '0;
        state_d = STATE_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if (refill_req_i) begin
        ram_req    = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = refill_addr_i;
        ram_data   = refill_data_i;
        refill_gnt = 1'b1;
      end else if (lookup_req_i) begin
        ram_req    = 1'b1;
        ram_addr   = lookup_addr_i;
        lookup_gnt = 1'b1;
      end
      // The access granted in this cycle still completes; the walk starts next cycle.
      if (flush_req_i) begin
        state_d = STATE_FLUSH;
        cnt_d   = '0;
      end
    end
  end

  assign valid_d = lookup_gnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Request-driven outputs are forced low while reset is held so the RAM and
  // the requesters see nothing even before the first clock edge.
  assign ram_req_o      = ram_req & ~rst_i;
  assign ram_we_o       = ram_we & ~rst_i;
  assign ram_addr_o     = rst_i ? '0 : ram_addr;
  assign ram_data_o     = rst_i ? '0 : ram_data;
  assign refill_gnt_o   = refill_gnt & ~rst_i;
  assign lookup_gnt_o   = lookup_gnt & ~rst_i;
  assign lookup_valid_o = valid_q;
  assign lookup_data_o  = valid_q ? ram_data_i : '0;
  assign flush_busy_o   = (state_q == STATE_FLUSH);

endmodule
